// File: rtl/clk_div_pkg.sv
// Shared constants, per-channel state type and phase helpers for the programmable clock divider.

package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DIV_MIN   = 2;

  // Channel state at the default counter width.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [CNT_W_DEF-1:0] act_div;
    logic [CNT_W_DEF-1:0] pend_div;
    logic                 pend_vld;
  } ch_state_t;

  // Length of the high phase; odd divisors give the extra cycle to the high phase.
  function automatic int unsigned high_len(input int unsigned d);
    return d - (d / 2);
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of clk_div_prog; tick_q exists only when CLK_DIV_QTICK_EN is defined.

interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned NUM_CH = 2
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick_rise;
  logic [NUM_CH-1:0] tick_fall;
  logic              cfg_err;

`ifdef CLK_DIV_QTICK_EN
  logic [NUM_CH-1:0] tick_q;

  modport master (
    output en, div_wr, div_ch, div_val,
    input  clk_out, tick_rise, tick_fall, cfg_err, tick_q
  );

  modport slave (
    input  en, div_wr, div_ch, div_val,
    output clk_out, tick_rise, tick_fall, cfg_err, tick_q
  );
`else
  modport master (
    output en, div_wr, div_ch, div_val,
    input  clk_out, tick_rise, tick_fall, cfg_err
  );

  modport slave (
    input  en, div_wr, div_ch, div_val,
    output clk_out, tick_rise, tick_fall, cfg_err
  );
`endif

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, phase compare, pending/active divisor swap and tick strobes.
// Quarter-point strobe tick_q_o is built only when CLK_DIV_QTICK_EN is defined.

module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             clk_out_o,
  output logic             tick_rise_o,
`ifdef CLK_DIV_QTICK_EN
  output logic             tick_q_o,
`endif
  output logic             tick_fall_o
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] pend_div;
    logic             pend_vld;
    logic             run;
  } state_t;

  state_t           st_q, st_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             wrap;
  logic             swap;
  logic [CNT_W-1:0] hi_len;

  always_comb begin
    st_d = st_q;
    wrap = st_q.run && (st_q.cnt == st_q.act_div - CNT_W'(1));
    // A stopped or just-starting channel picks up a pending divisor at once.
    swap = st_q.pend_vld && (!en_i || !st_q.run || wrap);

    if (!en_i) begin
      st_d.run = 1'b0;
      st_d.cnt = '0;
    end else if (!st_q.run || wrap) begin
      st_d.run = 1'b1;
      st_d.cnt = '0;
    end else begin
      st_d.cnt = st_q.cnt + CNT_W'(1);
    end

    if (swap) begin
      st_d.act_div  = st_q.pend_div;
      st_d.pend_vld = 1'b0;
    end

    // Applied after the swap so a write on the wrap cycle waits for the next boundary.
    if (wr_i) begin
      st_d.pend_div = wr_div_i;
      st_d.pend_vld = 1'b1;
    end
  end

  assign hi_len    = CNT_W'(high_len(32'(st_d.act_div)));
  assign clk_out_d = en_i && (st_d.cnt < hi_len);
  assign rise_d    = clk_out_d && !clk_out_q;
  assign fall_d    = !clk_out_d && clk_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q.cnt      <= '0;
      st_q.act_div  <= CNT_W'(DEFAULT_DIV);
      st_q.pend_div <= CNT_W'(DEFAULT_DIV);
      st_q.pend_vld <= 1'b0;
      st_q.run      <= 1'b0;
      clk_out_q     <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
    end else begin
      st_q      <= st_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign clk_out_o   = clk_out_q;
  assign tick_rise_o = rise_q;
  assign tick_fall_o = fall_q;

`ifdef CLK_DIV_QTICK_EN
  logic             qtick_q, qtick_d;
  logic [CNT_W-1:0] q_hi, q_lo;

  assign q_hi    = st_d.act_div >> 2;
  assign q_lo    = hi_len + ((st_d.act_div - hi_len) >> 1);
  assign qtick_d = en_i && ((st_d.cnt == q_hi) || (st_d.cnt == q_lo));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qtick_q <= 1'b0;
    end else begin
      qtick_q <= qtick_d;
    end
  end

  assign tick_q_o = qtick_q;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider: write decode, divisor clamping, sticky cfg_err.
// Define CLK_DIV_QTICK_EN to add per-channel quarter-point strobes (tick_q).

module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_div_prog_if.slave  bus
);

  logic              ch_ok;
  logic              div_low;
  logic [CNT_W-1:0]  div_clamped;
  logic [NUM_CH-1:0] ch_wr;
  logic              cfg_err_q, cfg_err_d;

  assign ch_ok       = 32'(bus.div_ch) < NUM_CH;
  assign div_low     = (bus.div_val[CNT_W-1:1] == '0);
  assign div_clamped = div_low ? CNT_W'(DIV_MIN) : bus.div_val;

  always_comb begin
    ch_wr = '0;
    if (bus.div_wr && ch_ok) begin
      ch_wr[bus.div_ch] = 1'b1;
    end
  end

  assign cfg_err_d = cfg_err_q || (bus.div_wr && (!ch_ok || div_low));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (bus.en[g]),
      .wr_i        (ch_wr[g]),
      .wr_div_i    (div_clamped),
      .clk_out_o   (bus.clk_out[g]),
      .tick_rise_o (bus.tick_rise[g]),
`ifdef CLK_DIV_QTICK_EN
      .tick_q_o    (bus.tick_q[g]),
`endif
      .tick_fall_o (bus.tick_fall[g])
    );
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable, multi-channel clock divider. Successor to the fixed 100 MHz → 1 MHz divider.
- Each channel produces a divided level output plus single-cycle rise/fall strobes. The strobes are for use as clock enables in the clk domain, e.g. I2C SCL timing or DHT11 microsecond sampling.
- Divisors are loaded through a simple write port. A new divisor takes effect glitch-free at the next period boundary.

Parameters:
- CNT_W, 16, counter/divisor width in bits.
- NUM_CH, 2, number of independent divider channels.
- DEFAULT_DIV, 100, per-channel divisor after reset (100 MHz → 1 MHz).

Ports:
- clk, input, 1, system clock (100 MHz nominal).
- rst_n, input, 1, asynchronous active-low reset.
- en, input, NUM_CH, per-channel run enable.
- div_wr, input, 1, one-cycle divisor write strobe.
- div_ch, input, $clog2(NUM_CH) (min 1), target channel for the write.
- div_val, input, CNT_W, divisor D = output period in clk cycles.
- clk_out, output, NUM_CH, divided level per channel (registered).
- tick_rise, output, NUM_CH, one-cycle strobe coincident with clk_out 0→1.
- tick_fall, output, NUM_CH, one-cycle strobe coincident with clk_out 1→0.
- cfg_err, output, 1, sticky flag: an illegal divisor was written.

Behaviour:
- Reset (async, rst_n low):
  - Counters = 0, clk_out = 0, ticks = 0, cfg_err = 0.
  - Active and pending divisors = DEFAULT_DIV.
  - Reset mid-period aborts the period immediately; no strobe is emitted.
- Per channel:
  - Counter cnt runs 0..D-1 and wraps to 0.
  - High phase H = D - floor(D/2), i.e. the high phase gets the extra cycle for odd D.
  - clk_out is high for cnt in [0, H-1] and low for cnt in [H, D-1].
  - Examples: D=2 → 1 high / 1 low; D=5 → 3 high / 2 low.
- en low:
  - cnt held at 0, clk_out forced 0, no ticks.
  - If en falls while clk_out is high, clk_out drops the next cycle and tick_fall pulses once.
- en rising, latency 1: the cycle after en is sampled high, clk_out = 1 and tick_rise = 1. A full period of D cycles then follows.
- Ticks:
  - tick_rise/tick_fall are registered with clk_out.
  - Each is high exactly one cycle per transition. They are never both high in the same channel.
- Divisor write (div_wr high):
  - div_val is latched into the pending register of channel div_ch.
  - Channel running: pending is copied to active on the cycle cnt wraps D-1 → 0. The current period always completes with the old D.
  - Channel disabled: pending is copied to active immediately, so it is used from the next enable.
  - Multiple writes before a boundary: last write wins.
  - A write on the exact cycle of the wrap is applied at the next boundary, not the current one.
  - div_ch ≥ NUM_CH: the write is ignored and cfg_err is set.
- Illegal divisor:
  - div_val < 2 is stored as 2 and cfg_err is set.
  - cfg_err stays set until reset.
- Arithmetic:
  - Unsigned CNT_W; no widening.
  - Maximum period 2^CNT_W - 1.
  - Comparisons use the active divisor only.
- Channels are fully independent. Simultaneous writes to different channels cannot occur: there is one write port.

Optional Feature:
- Macro: CLK_DIV_QTICK_EN.
- Defined:
  - Adds output tick_q[NUM_CH], a one-cycle strobe at cnt == floor(D/4) (mid-high) and at cnt == H + floor((D-H)/2) (mid-low).
  - tick_q is registered and aligned like the other ticks.
  - Used for I2C SDA change/sample points.
- Undefined: the port is absent and the quarter-point logic is not built.

Decomposition:
- Package clk_div_pkg:
  - DIV_MIN = 2.
  - Default CNT_W = 16.
  - Per-channel state type (cnt, active divisor, pending divisor, pending-valid).
  - Helper function computing H from D.
- Sub-module clk_div_ch:
  - One channel: counter, phase compare, pending/active swap, tick generation.
  - Instantiated NUM_CH times by generate in clk_div_prog.
  - The top level holds write decode and cfg_err.

Test Plan:
- Reset with DEFAULT_DIV = 100, en[0] = 1 → clk_out[0] high 50 / low 50 cycles; tick_rise every 100 cycles; first tick_rise 1 cycle after en is sampled.
- Write D = 5 to ch1 while running at 100, mid-period → old period completes, then 3 high / 2 low; no short or glitched pulse at the switch.
- Write D = 0 and D = 1 → channel runs at D = 2 (1/1 toggle every cycle); cfg_err = 1 and stays 1 after a later legal write.
- Drop en[0] while clk_out[0] high → next cycle clk_out = 0 with a single tick_fall; re-enable → tick_rise 1 cycle later and counter restarts at 0.
- Two writes to ch0 (D = 10, then D = 20) within one period → only D = 20 takes effect at the boundary; ch1 period unchanged throughout.
- Assert rst_n low mid-period (async, between clk edges) → all outputs 0 immediately; after release, divisors are back at 100.
